// File: rtl/dec_exec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dec_exec_issue_ctrl
//
// Issue scheduler sitting between decode and execute. It owns one registered
// decode-to-execute slot and a per-register scoreboard that counts writes which
// have been issued but not yet retired by writeback. Decode is stalled on RAW
// hazards (a source register still has an outstanding write) and on WAW
// hazards (the destination register still has an outstanding write), which
// keeps retirement in order per register. A branch/exception flush drops a
// slot that execute has not yet accepted and undoes its scoreboard increment.
//
// Optional feature, selected by the macro DEC_EXEC_ISSUE_WAW_PASS_EN:
//   undefined (default) : strict WAW stall, at most one write in flight per reg.
//   defined             : writes to a busy register may issue until its counter
//                         saturates at 2**CNT_W-1; sources still stall while
//                         the counter is non-zero.
//
// Parameters:
//   PKT_W  width of the opaque decoded packet forwarded to execute
//   CNT_W  width of each per-register outstanding-write counter
//   NREG   architectural register count (REG_W = $clog2(NREG))
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   dec_vld / dec_rdy        decode handshake (dec_rdy is combinational and
//                            independent of dec_vld)
//   dec_pkt                  decoded packet
//   dec_rs/_use, dec_rt/_use source registers and their read enables
//   dec_rd, dec_wr_en        destination register and its write enable
//   dec_exec_vld/_rdy/_pkt   execute channel, this block is the master
//   wb_vld, wb_reg           writeback retiring one register write
//   flush                    discard the un-accepted slot, block issue
//   sb_busy                  registered: some counter is non-zero
//   sb_err                   sticky: writeback to a register with zero count
//
// Register 0 is hard-wired: never counted, never a hazard, its writebacks are
// ignored.
// -----------------------------------------------------------------------------
module dec_exec_issue_ctrl #(
  parameter  int PKT_W = 64,
  parameter  int CNT_W = 2,
  parameter  int NREG  = 32,
  localparam int REG_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             resetn,
  // decode side
  input  logic             dec_vld,
  output logic             dec_rdy,
  input  logic [PKT_W-1:0] dec_pkt,
  input  logic [REG_W-1:0] dec_rs,
  input  logic             dec_rs_use,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_rt_use,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_wr_en,
  // execute side
  output logic             dec_exec_vld,
  input  logic             dec_exec_rdy,
  output logic [PKT_W-1:0] dec_exec_pkt,
  // writeback / control
  input  logic             wb_vld,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             flush,
  // status
  output logic             sb_busy,
  output logic             sb_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             slot_vld_q, slot_vld_d;
  logic [PKT_W-1:0] slot_pkt_q, slot_pkt_d;
  // Destination of the held slot and whether issuing it bumped a counter;
  // needed so a flush can undo exactly that increment.
  logic [REG_W-1:0] slot_rd_q,  slot_rd_d;
  logic             slot_inc_q, slot_inc_d;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic             sb_busy_q, sb_busy_d;
  logic             sb_err_q,  sb_err_d;

  // ---------------------------------------------------------------------------
  // Hazard detection against the registered counters (no writeback bypass)
  // ---------------------------------------------------------------------------
  logic rs_haz, rt_haz, rd_haz, hazard;

  assign rs_haz = dec_rs_use && (dec_rs != '0) && (cnt_q[dec_rs] != '0);
  assign rt_haz = dec_rt_use && (dec_rt != '0) && (cnt_q[dec_rt] != '0);

`ifdef DEC_EXEC_ISSUE_WAW_PASS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A write may overtake earlier writes to the same register; only a full
  // counter stops it.
  assign rd_haz = dec_wr_en && (dec_rd != '0) && (cnt_q[dec_rd] == CNT_MAX);
`else
  // Any outstanding write to the destination stalls, so at most one write per
  // register is ever in flight and retirement order is trivially preserved.
  assign rd_haz = dec_wr_en && (dec_rd != '0) && (cnt_q[dec_rd] != '0);
`endif

  assign hazard = rs_haz || rt_haz || rd_haz;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic slot_free;
  logic issue;
  logic issue_inc;
  logic flush_drop;

  assign slot_free  = !slot_vld_q || dec_exec_rdy;
  // resetn is folded in so decode sees no acceptance while reset is asserted.
  assign dec_rdy    = resetn && slot_free && !hazard && !flush;
  assign issue      = dec_vld && dec_rdy;
  assign issue_inc  = issue && dec_wr_en && (dec_rd != '0);
  // A flush only removes the slot if execute is not taking it this cycle;
  // an accepted instruction is already committed downstream.
  assign flush_drop = flush && slot_vld_q && !dec_exec_rdy;

  // ---------------------------------------------------------------------------
  // Slot next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // otherwise synthesis would infer a latch.
    slot_vld_d = slot_vld_q;
    slot_pkt_d = slot_pkt_q;
    slot_rd_d  = slot_rd_q;
    slot_inc_d = slot_inc_q;

    if (flush_drop) begin
      slot_vld_d = 1'b0;
      slot_inc_d = 1'b0;
    end else if (issue) begin
      slot_vld_d = 1'b1;
      slot_pkt_d = dec_pkt;
      slot_rd_d  = dec_rd;
      slot_inc_d = issue_inc;
    end else if (dec_exec_rdy) begin
      // Drained with nothing behind it.
      slot_vld_d = 1'b0;
      slot_inc_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  //
  // Per register: avail = cnt - flush_undo; a writeback consumes one from
  // avail (or flags an error if nothing is left); the issue increment is added
  // last. An increment never meets a full counter because the hazard logic
  // refused the issue in that case.
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] avail;
  logic           hit_inc, hit_wb, hit_undo;
  logic           wb_err;
  logic           busy_any;

  always_comb begin
    avail    = '0;
    hit_inc  = 1'b0;
    hit_wb   = 1'b0;
    hit_undo = 1'b0;
    wb_err   = 1'b0;
    busy_any = 1'b0;

    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      avail    = '0;
      hit_inc  = 1'b0;
      hit_wb   = 1'b0;
      hit_undo = 1'b0;

      if (r != 0) begin
        hit_inc  = issue_inc && (dec_rd == REG_W'(r));
        hit_wb   = wb_vld && (wb_reg == REG_W'(r));
        hit_undo = flush_drop && slot_inc_q && (slot_rd_q == REG_W'(r));

        avail = {1'b0, cnt_q[r]} - {{CNT_W{1'b0}}, hit_undo};
        if (hit_wb) begin
          if (avail == '0) begin
            // Retiring a write that was never issued: hold at zero, report.
            wb_err = 1'b1;
          end else begin
            avail = avail - 1'b1;
          end
        end
        avail    = avail + {{CNT_W{1'b0}}, hit_inc};
        cnt_d[r] = avail[CNT_W-1:0];
      end

      busy_any = busy_any || (cnt_d[r] != '0);
    end
  end

  // sb_busy is registered from the next-state counters so it lines up with
  // the counters themselves.
  assign sb_busy_d = busy_any;
  assign sb_err_d  = sb_err_q || wb_err;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_vld_q <= 1'b0;
      slot_pkt_q <= '0;
      slot_rd_q  <= '0;
      slot_inc_q <= 1'b0;
      sb_busy_q  <= 1'b0;
      sb_err_q   <= 1'b0;
      // NOTE: the counter array is real state that gates issue, not a data
      // buffer, so every entry is reset; a stale count would stall forever.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_pkt_q <= slot_pkt_d;
      slot_rd_q  <= slot_rd_d;
      slot_inc_q <= slot_inc_d;
      sb_busy_q  <= sb_busy_d;
      sb_err_q   <= sb_err_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dec_exec_vld = slot_vld_q;
  assign dec_exec_pkt = slot_pkt_q;
  assign sb_busy      = sb_busy_q;
  assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_dec_exec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dec_exec_issue_ctrl
//
// Directed bench for dec_exec_issue_ctrl. Inputs are driven 1 time unit after
// the rising edge; combinational outputs are sampled after a further settle
// delay and registered outputs after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_dec_exec_issue_ctrl;

  localparam int PKT_W = 64;
  localparam int CNT_W = 2;
  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  localparam logic [PKT_W-1:0] P_A = 64'hA5A5_0000_1111_0001;
  localparam logic [PKT_W-1:0] P_B = 64'hB0B0_2222_3333_0002;
  localparam logic [PKT_W-1:0] P_C = 64'hC0C0_4444_5555_0003;
  localparam logic [PKT_W-1:0] P_D = 64'hD0D0_6666_7777_0004;
  localparam logic [PKT_W-1:0] P_E = 64'hE0E0_8888_9999_0005;
  localparam logic [PKT_W-1:0] P_F = 64'hF0F0_AAAA_BBBB_0006;
  localparam logic [PKT_W-1:0] P_G = 64'h1234_CCCC_DDDD_0007;
  localparam logic [PKT_W-1:0] P_H = 64'h5678_EEEE_FFFF_0008;
  localparam logic [PKT_W-1:0] P_I = 64'h9ABC_0101_0202_0009;

  logic             clk;
  logic             resetn;
  logic             dec_vld;
  logic             dec_rdy;
  logic [PKT_W-1:0] dec_pkt;
  logic [REG_W-1:0] dec_rs;
  logic             dec_rs_use;
  logic [REG_W-1:0] dec_rt;
  logic             dec_rt_use;
  logic [REG_W-1:0] dec_rd;
  logic             dec_wr_en;
  logic             dec_exec_vld;
  logic             dec_exec_rdy;
  logic [PKT_W-1:0] dec_exec_pkt;
  logic             wb_vld;
  logic [REG_W-1:0] wb_reg;
  logic             flush;
  logic             sb_busy;
  logic             sb_err;

  int n_cmp = 0;
  int n_err = 0;

  dec_exec_issue_ctrl #(
    .PKT_W(PKT_W),
    .CNT_W(CNT_W),
    .NREG (NREG)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .dec_vld     (dec_vld),
    .dec_rdy     (dec_rdy),
    .dec_pkt     (dec_pkt),
    .dec_rs      (dec_rs),
    .dec_rs_use  (dec_rs_use),
    .dec_rt      (dec_rt),
    .dec_rt_use  (dec_rt_use),
    .dec_rd      (dec_rd),
    .dec_wr_en   (dec_wr_en),
    .dec_exec_vld(dec_exec_vld),
    .dec_exec_rdy(dec_exec_rdy),
    .dec_exec_pkt(dec_exec_pkt),
    .wb_vld      (wb_vld),
    .wb_reg      (wb_reg),
    .flush       (flush),
    .sb_busy     (sb_busy),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn       = 1'b0;
    dec_vld      = 1'b0;
    dec_pkt      = '0;
    dec_rs       = '0;
    dec_rs_use   = 1'b0;
    dec_rt       = '0;
    dec_rt_use   = 1'b0;
    dec_rd       = '0;
    dec_wr_en    = 1'b0;
    dec_exec_rdy = 1'b1;
    wb_vld       = 1'b0;
    wb_reg       = '0;
    flush        = 1'b0;

    // ---- reset state --------------------------------------------------------
    #12;
    check("rst_exec_vld", dec_exec_vld, 0);
    check("rst_exec_pkt", dec_exec_pkt, 0);
    check("rst_busy",     sb_busy,      0);
    check("rst_err",      sb_err,       0);
    check("rst_dec_rdy",  dec_rdy,      0);
    @(negedge clk) resetn = 1'b1;
    cyc();

    // ---- first issue: rd=5 --------------------------------------------------
    dec_vld = 1'b1; dec_rd = 5; dec_wr_en = 1'b1; dec_pkt = P_A;
    #1;
    check("t1_rdy", dec_rdy, 1);
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    #1;
    check("t1_exec_vld", dec_exec_vld, 1);
    check("t1_exec_pkt", dec_exec_pkt, P_A);
    check("t1_busy",     sb_busy,      1);

    // ---- RAW on rs=5 until writeback ----------------------------------------
    dec_vld = 1'b1; dec_pkt = P_B; dec_rs = 5; dec_rs_use = 1'b1;
    #1;
    check("t2_raw_stall", dec_rdy, 0);
    cyc();
    check("t2_drained",    dec_exec_vld, 0);
    check("t2_raw_stall2", dec_rdy,      0);
    wb_vld = 1'b1; wb_reg = 5;
    #1;
    check("t2_no_bypass", dec_rdy, 0);
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t2_rdy_after_wb", dec_rdy, 1);
    check("t2_busy_clear",   sb_busy, 0);
    cyc();
    dec_vld = 1'b0; dec_rs_use = 1'b0;
    #1;
    check("t2_exec_vld", dec_exec_vld, 1);
    check("t2_exec_pkt", dec_exec_pkt, P_B);

    // ---- execute backpressure for 3 cycles ----------------------------------
    dec_exec_rdy = 1'b0; dec_vld = 1'b1; dec_pkt = P_C;
    #1;
    check("t3_rdy_blocked", dec_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t3_hold_vld", dec_exec_vld, 1);
      check("t3_hold_pkt", dec_exec_pkt, P_B);
      check("t3_hold_rdy", dec_rdy,      0);
    end
    dec_exec_rdy = 1'b1;
    #1;
    check("t3_rdy_release", dec_rdy, 1);
    cyc();
    dec_vld = 1'b0;
    #1;
    check("t3_issue_vld", dec_exec_vld, 1);
    check("t3_issue_pkt", dec_exec_pkt, P_C);
    cyc();
    check("t3_single_issue", dec_exec_vld, 0);

    // ---- flush of held slot rd=7 --------------------------------------------
    dec_exec_rdy = 1'b0; dec_vld = 1'b1; dec_rd = 7; dec_wr_en = 1'b1; dec_pkt = P_D;
    #1;
    check("t4_rdy", dec_rdy, 1);
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    #1;
    check("t4_held_vld",  dec_exec_vld, 1);
    check("t4_held_busy", sb_busy,      1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    check("t4_flush_vld",  dec_exec_vld, 0);
    check("t4_flush_busy", sb_busy,      0);
    dec_rs = 7; dec_rs_use = 1'b1;
    #1;
    check("t4_undo_no_haz", dec_rdy, 1);
    dec_rs_use = 1'b0;

    // flush while execute accepts: not undone
    dec_vld = 1'b1; dec_rd = 7; dec_wr_en = 1'b1; dec_pkt = P_E;
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    flush = 1'b1; dec_exec_rdy = 1'b1; dec_vld = 1'b1; dec_pkt = P_F;
    #1;
    check("t4_flush_blocks_issue", dec_rdy, 0);
    cyc();
    flush = 1'b0; dec_vld = 1'b0;
    #1;
    check("t4_accept_vld",  dec_exec_vld, 0);
    check("t4_accept_busy", sb_busy,      1);
    dec_rs = 7; dec_rs_use = 1'b1;
    #1;
    check("t4_accept_haz", dec_rdy, 0);
    dec_rs_use = 1'b0;
    wb_vld = 1'b1; wb_reg = 7;
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t4_wb_busy", sb_busy, 0);
    check("t4_wb_err",  sb_err,  0);

    // ---- register 0 and spurious writeback ----------------------------------
    wb_vld = 1'b1; wb_reg = 0;
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t5_wb0_no_err", sb_err, 0);
    dec_vld = 1'b1; dec_rd = 0; dec_wr_en = 1'b1;
    #1;
    check("t5_rd0_rdy", dec_rdy, 1);
    cyc();
    dec_wr_en = 1'b0; dec_rs = 0; dec_rs_use = 1'b1;
    #1;
    check("t5_rs0_no_haz", dec_rdy, 1);
    check("t5_rd0_busy",   sb_busy, 0);
    dec_vld = 1'b0; dec_rs_use = 1'b0;
    cyc();
    wb_vld = 1'b1; wb_reg = 9;
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t5_err_set",  sb_err,  1);
    check("t5_err_busy", sb_busy, 0);
    cyc();
    cyc();
    check("t5_err_sticky", sb_err, 1);

    // ---- reset mid-operation ------------------------------------------------
    dec_exec_rdy = 1'b0; dec_vld = 1'b1; dec_rd = 12; dec_wr_en = 1'b1; dec_pkt = P_G;
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    #1;
    check("t6_pre_vld", dec_exec_vld, 1);
    resetn = 1'b0;
    #1;
    check("t6_rst_vld",  dec_exec_vld, 0);
    check("t6_rst_pkt",  dec_exec_pkt, 0);
    check("t6_rst_err",  sb_err,       0);
    check("t6_rst_busy", sb_busy,      0);
    check("t6_rst_rdy",  dec_rdy,      0);
    @(negedge clk) resetn = 1'b1;
    cyc();
    dec_exec_rdy = 1'b1; dec_rs = 12; dec_rs_use = 1'b1;
    #1;
    check("t6_cnt_cleared", dec_rdy, 1);
    dec_rs_use = 1'b0;

    // ---- same-cycle issue and writeback on rd=3 -----------------------------
    dec_vld = 1'b1; dec_rd = 3; dec_wr_en = 1'b1; dec_pkt = P_H;
    cyc();
    dec_pkt = P_I;
    #1;
`ifdef DEC_EXEC_ISSUE_WAW_PASS_EN
    check("t7_waw_pass_rdy", dec_rdy, 1);
    wb_vld = 1'b1; wb_reg = 3;
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0; wb_vld = 1'b0;
    #1;
`else
    check("t7_waw_stall", dec_rdy, 0);
    wb_vld = 1'b1; wb_reg = 3;
    #1;
    check("t7_waw_no_bypass", dec_rdy, 0);
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t7_waw_release", dec_rdy, 1);
    cyc();
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    #1;
`endif
    check("t7_exec_vld", dec_exec_vld, 1);
    check("t7_exec_pkt", dec_exec_pkt, P_I);
    check("t7_busy",     sb_busy,      1);
    dec_rs = 3; dec_rs_use = 1'b1;
    #1;
    check("t7_cnt_one_haz", dec_rdy, 0);
    dec_rs_use = 1'b0;
    wb_vld = 1'b1; wb_reg = 3;
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t7_busy_clear", sb_busy, 0);
    check("t7_no_err",     sb_err,  0);

`ifdef DEC_EXEC_ISSUE_WAW_PASS_EN
    // ---- three writes to rd=4 in flight, fourth stalls ----------------------
    dec_vld = 1'b1; dec_rd = 4; dec_wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t8_write_rdy", dec_rdy, 1);
      cyc();
    end
    #1;
    check("t8_fourth_stall", dec_rdy, 0);
    dec_vld = 1'b0; dec_wr_en = 1'b0;
    wb_vld = 1'b1; wb_reg = 4;
    cyc();
    cyc();
    check("t8_busy_partial", sb_busy, 1);
    cyc();
    wb_vld = 1'b0;
    #1;
    check("t8_busy_clear", sb_busy, 0);
    check("t8_no_err",     sb_err,  0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
